// File: rtl/music_sequencer_if.sv
// Song ROM read port: the sequencer presents an address, the ROM returns a word
// a fixed number of cycles later.
interface music_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/music_sequencer.sv
// Note sequencer for the music player: fetches note words from a song ROM,
// times each note in tempo ticks, and gates the speaker. Also holds the
// note_data pitch lookup that turns a note index into a speaker divider.

// Pitch lookup: note index 1..12 is one chromatic octave from C4, anything
// else (including the rest index 0) gives a divider of 0.
module note_data #(
  parameter int CLK_FREQ = 100
) (
  input  logic [7:0]  index,
  output logic [15:0] divider
);
  // Half-period in clocks for a tone, saturated to the divider width.
  function automatic logic [15:0] half_period(input int unsigned freq_hz);
    int unsigned ratio;
    ratio = int'(CLK_FREQ) / (32'd2 * freq_hz);
    if (ratio > 32'd65535) begin
      half_period = 16'hFFFF;
    end else begin
      half_period = ratio[15:0];
    end
  endfunction

  // Constant table selected by the current note index.
  always_comb begin
    divider = 16'd0;
    case (index)
      8'd1:    divider = half_period(32'd262);
      8'd2:    divider = half_period(32'd277);
      8'd3:    divider = half_period(32'd294);
      8'd4:    divider = half_period(32'd311);
      8'd5:    divider = half_period(32'd330);
      8'd6:    divider = half_period(32'd349);
      8'd7:    divider = half_period(32'd370);
      8'd8:    divider = half_period(32'd392);
      8'd9:    divider = half_period(32'd415);
      8'd10:   divider = half_period(32'd440);
      8'd11:   divider = half_period(32'd466);
      8'd12:   divider = half_period(32'd494);
      default: divider = 16'd0;
    endcase
  end
endmodule

module music_sequencer #(
  parameter int CLK_FREQ    = 100,
  parameter int ROM_WIDTH   = 16,
  parameter int ROM_SIZE    = 256,
  parameter int ROM_LATENCY = 1,
  parameter int DUR_WIDTH   = 4,
  parameter int TICK_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  loop_en,
  input  logic [TICK_WIDTH-1:0] tick_period,
  music_sequencer_if.master     rom,
  output logic [7:0]            note_index,
  output logic [15:0]           speaker_divider,
  output logic                  speaker_en,
  output logic                  playing,
  output logic                  song_done
);
  localparam int AW = $clog2(ROM_SIZE);
  localparam logic [2:0]    LAT_LAST  = 3'(ROM_LATENCY);
  localparam logic [AW-1:0] ADDR_LAST = AW'(ROM_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_PAUSED = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [AW-1:0]         addr_r, addr_s;
  logic [7:0]            note_r, note_s;
  logic [TICK_WIDTH-1:0] tick_r, tick_s;
  logic [TICK_WIDTH-1:0] period_r, period_s;
  logic [TICK_WIDTH-1:0] tp_eff_s, cur_p_s;
  logic [DUR_WIDTH-1:0]  remain_r, remain_s;
  logic [DUR_WIDTH-1:0]  word_dur_s, dur_eff_s;
  logic [2:0]            lat_r, lat_s;
  logic [7:0]            word_idx_s;
  logic                  word_eos_s;
  logic                  word_unused_s;
  logic                  spk_r, spk_s;
  logic                  playing_r, playing_s;
  logic                  done_r, done_s;

  // Field extraction from the current ROM word.
  assign word_idx_s    = rom.rom_data[7:0];
  assign word_dur_s    = rom.rom_data[8 +: DUR_WIDTH];
  assign word_eos_s    = rom.rom_data[ROM_WIDTH-1];
  assign word_unused_s = ^rom.rom_data;

  // A zero duration or zero tempo behaves as one so a note never stalls.
  assign dur_eff_s = (word_dur_s == {DUR_WIDTH{1'b0}}) ? DUR_WIDTH'(1) : word_dur_s;
  assign tp_eff_s  = (tick_period == {TICK_WIDTH{1'b0}}) ? TICK_WIDTH'(1) : tick_period;
  // Tempo is only picked up at a tick boundary; mid-tick the held period applies.
  assign cur_p_s   = (tick_r == {TICK_WIDTH{1'b0}}) ? tp_eff_s : period_r;

  // Next-state and next-register values; stop overrides every state.
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    note_s   = note_r;
    tick_s   = tick_r;
    period_s = period_r;
    remain_s = remain_r;
    lat_s    = lat_r;
    done_s   = 1'b0;
    if (stop) begin
      state_s  = ST_IDLE;
      addr_s   = {AW{1'b0}};
      note_s   = 8'd0;
      tick_s   = {TICK_WIDTH{1'b0}};
      period_s = {TICK_WIDTH{1'b0}};
      remain_s = {DUR_WIDTH{1'b0}};
      lat_s    = 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s = ST_FETCH;
            addr_s  = {AW{1'b0}};
            lat_s   = 3'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (lat_r != LAT_LAST) begin
            lat_s = lat_r + 3'd1;
          end else if (word_eos_s) begin
            addr_s = {AW{1'b0}};
            lat_s  = 3'd0;
            if (loop_en) begin
              state_s = ST_FETCH;
            end else begin
              state_s = ST_IDLE;
              done_s  = 1'b1;
            end
          end else begin
            note_s   = word_idx_s;
            remain_s = dur_eff_s;
            tick_s   = {TICK_WIDTH{1'b0}};
            lat_s    = 3'd0;
            addr_s   = (addr_r == ADDR_LAST) ? {AW{1'b0}} : addr_r + AW'(1);
            // A pause raised while fetching lands in PAUSED once the word is in.
            state_s  = pause ? ST_PAUSED : ST_PLAY;
          end
        end
        ST_PLAY: begin
          period_s = cur_p_s;
          if (tick_r == cur_p_s - TICK_WIDTH'(1)) begin
            tick_s   = {TICK_WIDTH{1'b0}};
            remain_s = remain_r - DUR_WIDTH'(1);
            if (remain_r == DUR_WIDTH'(1)) begin
              state_s = ST_FETCH;
              lat_s   = 3'd0;
            end else begin
              state_s = pause ? ST_PAUSED : ST_PLAY;
            end
          end else begin
            tick_s  = tick_r + TICK_WIDTH'(1);
            state_s = pause ? ST_PAUSED : ST_PLAY;
          end
        end
        ST_PAUSED: begin
          state_s = pause ? ST_PAUSED : ST_PLAY;
        end
        default: begin
          state_s  = ST_IDLE;
          addr_s   = {AW{1'b0}};
          note_s   = 8'd0;
          tick_s   = {TICK_WIDTH{1'b0}};
          period_s = {TICK_WIDTH{1'b0}};
          remain_s = {DUR_WIDTH{1'b0}};
          lat_s    = 3'd0;
        end
      endcase
    end
    spk_s     = (state_s == ST_PLAY) && (note_s != 8'd0);
    playing_s = (state_s != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r    <= {AW{1'b0}};
      note_r    <= 8'd0;
      tick_r    <= {TICK_WIDTH{1'b0}};
      period_r  <= {TICK_WIDTH{1'b0}};
      remain_r  <= {DUR_WIDTH{1'b0}};
      lat_r     <= 3'd0;
      spk_r     <= 1'b0;
      playing_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      addr_r    <= addr_s;
      note_r    <= note_s;
      tick_r    <= tick_s;
      period_r  <= period_s;
      remain_r  <= remain_s;
      lat_r     <= lat_s;
      spk_r     <= spk_s;
      playing_r <= playing_s;
      done_r    <= done_s;
    end
  end

  assign rom.rom_addr = addr_r;
  assign note_index   = note_r;
  assign speaker_en   = spk_r;
  assign playing      = playing_r;
  assign song_done    = done_r;

  note_data #(.CLK_FREQ(CLK_FREQ)) u_note_data (
    .index   (note_r),
    .divider (speaker_divider)
  );
endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench: dut0 is a 256-word, latency-1 sequencer at 1 MHz; dut1 is a
// 4-word, latency-0 sequencer used for address wrap.
module tb_music_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, stop0 = 1'b0, pause0 = 1'b0, loop0 = 1'b0;
  logic [23:0] tp0 = 24'd4;
  logic [7:0]  note0;
  logic [15:0] div0;
  logic        spk0, play0, done0;
  logic        start1 = 1'b0, stop1 = 1'b0, pause1 = 1'b0, loop1 = 1'b0;
  logic [23:0] tp1 = 24'd1;
  logic [7:0]  note1;
  logic [15:0] div1;
  logic        spk1, play1, done1;

  logic [15:0] rom0 [0:255];
  logic [15:0] rom1 [0:3];

  int n_vec = 0;
  int n_bad = 0;

  int s_addr [0:63];
  int s_note [0:63];
  int s_div  [0:63];
  int s_spk  [0:63];
  int s_play [0:63];
  int s_done [0:63];

  music_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus0 ();
  music_sequencer_if #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) bus1 ();

  music_sequencer #(.CLK_FREQ(1000000), .ROM_SIZE(256), .ROM_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0), .pause(pause0),
    .loop_en(loop0), .tick_period(tp0), .rom(bus0.master), .note_index(note0),
    .speaker_divider(div0), .speaker_en(spk0), .playing(play0), .song_done(done0)
  );

  music_sequencer #(.ROM_SIZE(4), .ROM_LATENCY(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .pause(pause1),
    .loop_en(loop1), .tick_period(tp1), .rom(bus1.master), .note_index(note1),
    .speaker_divider(div1), .speaker_en(spk1), .playing(play1), .song_done(done1)
  );

  always #5 clk = ~clk;

  // One-cycle-latency synchronous ROM for dut0, combinational ROM for dut1.
  always @(posedge clk) bus0.rom_data <= rom0[bus0.rom_addr];
  assign bus1.rom_data = rom1[bus1.rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture0(input int i);
    s_addr[i] = int'(bus0.rom_addr);
    s_note[i] = int'(note0);
    s_div[i]  = int'(div0);
    s_spk[i]  = int'(spk0);
    s_play[i] = int'(play0);
    s_done[i] = int'(done0);
  endtask

  task automatic load_rom0(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    for (int k = 0; k < 256; k++) rom0[k] = 16'h8000;
    rom0[0] = w0;
    rom0[1] = w1;
    rom0[2] = w2;
  endtask

  // Start dut0 and record cycles 1..n (cycle k follows the k-th edge after start).
  task automatic run0(input int n, input int pause_from, input int pause_to);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 1; i <= n; i++) begin
      pause0 = (i >= pause_from) && (i <= pause_to);
      capture0(i);
      tick();
    end
    pause0 = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (bus0.rom_addr !== 8'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", bus0.rom_addr); end
    n_vec++; if (note0 !== 8'd0) begin n_bad++; $display("FAIL reset_note got %0d want 0", note0); end
    n_vec++; if (div0 !== 16'd0) begin n_bad++; $display("FAIL reset_div got %0d want 0", div0); end
    n_vec++; if ({spk0, play0, done0} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {spk0, play0, done0}); end
    n_vec++; if ({spk1, play1, done1} !== 3'b000) begin n_bad++; $display("FAIL reset_flags1 got %b want 000", {spk1, play1, done1}); end
    #2 rst_n = 1'b1;
    tick(); tick();
    n_vec++; if (play0 !== 1'b0) begin n_bad++; $display("FAIL reset_idle got %0d want 0", play0); end
  endtask

  task automatic test_song();
    int spk_cnt, done_cnt;
    load_rom0(16'h0305, 16'h0200, 16'h8000);
    tp0 = 24'd4; loop0 = 1'b0;
    run0(32, 0, -1);
    spk_cnt = 0; done_cnt = 0;
    for (int i = 1; i <= 32; i++) begin spk_cnt += s_spk[i]; done_cnt += s_done[i]; end
    n_vec++; if (s_play[1] !== 1) begin n_bad++; $display("FAIL song_play_c1 got %0d want 1", s_play[1]); end
    n_vec++; if (s_spk[2] !== 0) begin n_bad++; $display("FAIL song_spk_c2 got %0d want 0", s_spk[2]); end
    n_vec++; if (s_spk[3] !== 1) begin n_bad++; $display("FAIL song_spk_c3 got %0d want 1", s_spk[3]); end
    n_vec++; if (s_note[3] !== 5) begin n_bad++; $display("FAIL song_note_c3 got %0d want 5", s_note[3]); end
    n_vec++; if (s_div[3] !== 1515) begin n_bad++; $display("FAIL song_div_c3 got %0d want 1515", s_div[3]); end
    n_vec++; if (s_addr[3] !== 1) begin n_bad++; $display("FAIL song_addr_c3 got %0d want 1", s_addr[3]); end
    n_vec++; if (s_spk[14] !== 1 || s_spk[15] !== 0) begin n_bad++; $display("FAIL song_note_end got %0d%0d want 10", s_spk[14], s_spk[15]); end
    n_vec++; if (spk_cnt !== 12) begin n_bad++; $display("FAIL song_gate_cycles got %0d want 12", spk_cnt); end
    n_vec++; if (s_note[17] !== 0 || s_addr[17] !== 2) begin n_bad++; $display("FAIL song_rest got note %0d addr %0d want 0 2", s_note[17], s_addr[17]); end
    n_vec++; if (s_addr[16] !== 1 || s_addr[26] !== 2) begin n_bad++; $display("FAIL song_fetch_len got %0d %0d want 1 2", s_addr[16], s_addr[26]); end
    n_vec++; if (done_cnt !== 1 || s_done[27] !== 1) begin n_bad++; $display("FAIL song_done got cnt %0d c27 %0d want 1 1", done_cnt, s_done[27]); end
    n_vec++; if (s_play[26] !== 1 || s_play[27] !== 0) begin n_bad++; $display("FAIL song_play_fall got %0d%0d want 10", s_play[26], s_play[27]); end
    n_vec++; if (s_addr[27] !== 0) begin n_bad++; $display("FAIL song_addr_end got %0d want 0", s_addr[27]); end
  endtask

  task automatic test_loop();
    int done_cnt, play_cnt;
    load_rom0(16'h0305, 16'h0200, 16'h8000);
    loop0 = 1'b1;
    run0(60, 0, -1);
    done_cnt = 0; play_cnt = 0;
    for (int i = 1; i <= 60; i++) begin done_cnt += s_done[i]; play_cnt += s_play[i]; end
    n_vec++; if (s_addr[2] !== 0 || s_addr[3] !== 1 || s_addr[17] !== 2) begin n_bad++; $display("FAIL loop_lap1 got %0d %0d %0d want 0 1 2", s_addr[2], s_addr[3], s_addr[17]); end
    n_vec++; if (s_addr[27] !== 0 || s_addr[28] !== 0) begin n_bad++; $display("FAIL loop_restart got %0d %0d want 0 0", s_addr[27], s_addr[28]); end
    n_vec++; if (s_addr[29] !== 1 || s_addr[43] !== 2 || s_addr[53] !== 0 || s_addr[55] !== 1) begin n_bad++; $display("FAIL loop_lap2 got %0d %0d %0d %0d want 1 2 0 1", s_addr[29], s_addr[43], s_addr[53], s_addr[55]); end
    n_vec++; if (s_note[29] !== 5) begin n_bad++; $display("FAIL loop_note got %0d want 5", s_note[29]); end
    n_vec++; if (done_cnt !== 0 || play_cnt !== 60) begin n_bad++; $display("FAIL loop_flags got done %0d play %0d want 0 60", done_cnt, play_cnt); end
    stop0 = 1'b1; tick(); stop0 = 1'b0; loop0 = 1'b0;
  endtask

  task automatic test_short();
    int spk_cnt;
    load_rom0(16'h0001, 16'h8000, 16'h8000);
    tp0 = 24'd0;
    run0(8, 0, -1);
    spk_cnt = 0;
    for (int i = 1; i <= 8; i++) spk_cnt += s_spk[i];
    n_vec++; if (s_spk[3] !== 1 || s_spk[4] !== 0) begin n_bad++; $display("FAIL short_gate got %0d%0d want 10", s_spk[3], s_spk[4]); end
    n_vec++; if (spk_cnt !== 1) begin n_bad++; $display("FAIL short_len got %0d want 1", spk_cnt); end
    n_vec++; if (s_done[6] !== 1 || s_play[5] !== 1 || s_play[6] !== 0) begin n_bad++; $display("FAIL short_done got %0d %0d %0d want 1 1 0", s_done[6], s_play[5], s_play[6]); end
    tp0 = 24'd4;
  endtask

  task automatic test_pause();
    int spk_cnt, paused_spk;
    load_rom0(16'h0305, 16'h8000, 16'h8000);
    run0(32, 6, 15);
    spk_cnt = 0; paused_spk = 0;
    for (int i = 1; i <= 32; i++) spk_cnt += s_spk[i];
    for (int i = 7; i <= 16; i++) paused_spk += s_spk[i];
    n_vec++; if (paused_spk !== 0 || s_play[10] !== 1) begin n_bad++; $display("FAIL pause_gate got spk %0d play %0d want 0 1", paused_spk, s_play[10]); end
    n_vec++; if (s_spk[6] !== 1 || s_spk[17] !== 1) begin n_bad++; $display("FAIL pause_resume got %0d %0d want 1 1", s_spk[6], s_spk[17]); end
    n_vec++; if (spk_cnt !== 12) begin n_bad++; $display("FAIL pause_play_cycles got %0d want 12", spk_cnt); end
    n_vec++; if (s_addr[26] !== 1 || s_addr[27] !== 0 || s_done[27] !== 1) begin n_bad++; $display("FAIL pause_len got %0d %0d %0d want 1 0 1", s_addr[26], s_addr[27], s_done[27]); end
  endtask

  task automatic test_stop();
    int done_cnt;
    load_rom0(16'h0305, 16'h0200, 16'h8000);
    start0 = 1'b1; tick(); start0 = 1'b0;
    repeat (5) tick();
    n_vec++; if (spk0 !== 1'b1) begin n_bad++; $display("FAIL stop_pre got %0d want 1", spk0); end
    stop0 = 1'b1; tick(); stop0 = 1'b0;
    n_vec++; if ({play0, spk0, done0} !== 3'b000 || bus0.rom_addr !== 8'd0 || note0 !== 8'd0) begin n_bad++; $display("FAIL stop_idle got flags %b addr %0d note %0d want 000 0 0", {play0, spk0, done0}, bus0.rom_addr, note0); end
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); done_cnt += int'(done0); end
    n_vec++; if (done_cnt !== 0) begin n_bad++; $display("FAIL stop_no_done got %0d want 0", done_cnt); end
    stop0 = 1'b1; start0 = 1'b1; tick(); stop0 = 1'b0; start0 = 1'b0;
    n_vec++; if (play0 !== 1'b0) begin n_bad++; $display("FAIL stop_beats_start got %0d want 0", play0); end
    tick();
    n_vec++; if (play0 !== 1'b0) begin n_bad++; $display("FAIL stop_beats_start2 got %0d want 0", play0); end
    start0 = 1'b1; tick(); start0 = 1'b0;
    repeat (14) tick();
    n_vec++; if (note0 !== 8'd5 || bus0.rom_addr !== 8'd1 || play0 !== 1'b1 || spk0 !== 1'b0) begin n_bad++; $display("FAIL rst_pre got note %0d addr %0d play %0d spk %0d want 5 1 1 0", note0, bus0.rom_addr, play0, spk0); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (note0 !== 8'd0 || bus0.rom_addr !== 8'd0 || div0 !== 16'd0) begin n_bad++; $display("FAIL rst_async got note %0d addr %0d div %0d want 0 0 0", note0, bus0.rom_addr, div0); end
    n_vec++; if ({play0, spk0, done0} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {play0, spk0, done0}); end
    tick();
    #2 rst_n = 1'b1;
    repeat (3) tick();
    n_vec++; if (play0 !== 1'b0 || bus0.rom_addr !== 8'd0) begin n_bad++; $display("FAIL rst_stays_idle got play %0d addr %0d want 0 0", play0, bus0.rom_addr); end
  endtask

  task automatic test_wrap();
    int a [0:15];
    int nt [0:15];
    int pl [0:15];
    rom1[0] = 16'h0101; rom1[1] = 16'h0102; rom1[2] = 16'h0103; rom1[3] = 16'h0104;
    tp1 = 24'd1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      a[i] = int'(bus1.rom_addr); nt[i] = int'(note1); pl[i] = int'(spk1);
      tick();
    end
    n_vec++; if (a[1] !== 0 || a[2] !== 1 || nt[2] !== 1 || pl[2] !== 1 || pl[3] !== 0) begin n_bad++; $display("FAIL wrap_first got addr %0d note %0d spk %0d%0d want 1 1 10", a[2], nt[2], pl[2], pl[3]); end
    n_vec++; if (a[6] !== 3 || nt[6] !== 3) begin n_bad++; $display("FAIL wrap_last got addr %0d note %0d want 3 3", a[6], nt[6]); end
    n_vec++; if (a[8] !== 0 || nt[8] !== 4) begin n_bad++; $display("FAIL wrap_to_zero got addr %0d note %0d want 0 4", a[8], nt[8]); end
    n_vec++; if (a[10] !== 1 || nt[10] !== 1 || play1 !== 1'b1) begin n_bad++; $display("FAIL wrap_continue got addr %0d note %0d play %0d want 1 1 1", a[10], nt[10], play1); end
    stop1 = 1'b1; tick(); stop1 = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) rom0[k] = 16'h8000;
    for (int k = 0; k < 4; k++) rom1[k] = 16'h8000;
    repeat (2) tick();
    test_reset();
    test_song();
    test_loop();
    test_short();
    test_pause();
    test_stop();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
